// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_ext block: read-mode enum,
// count-width and pointer-wrap functions.
package sync_fifo_pkg;

    typedef enum logic {
        SYNC_READ = 1'b0,
        FWFT_READ = 1'b1
    } read_mode_e;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a storage index by one, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, registered or FWFT read, thresholds
// and sticky error flags. Define SYNC_FIFO_STATS_EN to add the peak_count output.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 12,
    parameter int FWFT_MODE = 0,
    parameter int CW        = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic             underflow,
    input  logic             err_clr,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic [CW-1:0]    count
`ifdef SYNC_FIFO_STATS_EN
    ,
    output logic [CW-1:0]    peak_count
`endif
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam read_mode_e    MODE    = (FWFT_MODE != 0) ? FWFT_READ : SYNC_READ;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_evt;
    logic             unf_evt;
    logic             overflow_q;
    logic             underflow_q;
    logic [WIDTH-1:0] mem_rdata;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return PW'(ptr_inc(32'(p), DEPTH));
    endfunction

    // Handshake: a write transfers on an edge where wr_en is high and wr_acc
    // holds (not full, or full with a same-cycle accepted read); a read is
    // accepted when rd_en is high, the FIFO is not empty and flush is low.
    // FWFT: rd_valid/rd_data present the head word and rd_en consumes it.
    // Registered: an accepted read returns its word with a one-cycle rd_valid
    // pulse on the following cycle. flush overrides both requests.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc  = rd_en & ~empty & ~flush;
    assign wr_acc  = wr_en & ~flush & (~full | rd_acc);
    assign ovf_evt = wr_en & ~wr_acc & ~flush;
    assign unf_evt = rd_en & empty & ~flush;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q <= count_nxt;
        end
    end

    // A set event on the same edge takes priority over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (unf_evt) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (MODE == FWFT_READ) begin : g_fwft
            assign rd_data  = mem_rdata;
            assign rd_valid = ~empty;
        end else begin : g_sync
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // rd_data holds its last value between reads and across flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_STATS_EN
    logic [CW-1:0] peak_q;

    // Tracks the occupancy being loaded this edge so peak never trails count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (flush || err_clr) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 12, entries; any integer >=2, not restricted to powers of 2.
REQ-003 SHALL have parameter FWFT_MODE, default 0; 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
REQ-004 SHALL have derived parameter CW = $clog2(DEPTH+1), count and threshold width.
REQ-005 SHALL have ports, with one clock and an asynchronous active-low reset:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous reset, active low
 flush  in  1  synchronous clear of contents
 wr_en  in  1  write request
 wr_data  in  WIDTH  write data
 full  out  1  count == DEPTH
 almost_full  out  1  count >= af_thresh
 overflow  out  1  sticky, a write was dropped
 rd_en  in  1  read request
 rd_data  out  WIDTH  read data
 rd_valid  out  1  rd_data is valid
 empty  out  1  count == 0
 almost_empty  out  1  count <= ae_thresh
 underflow  out  1  sticky, a read was refused
 err_clr  in  1  clears overflow and underflow
 af_thresh  in  CW  almost-full threshold
 ae_thresh  in  CW  almost-empty threshold
 count  out  CW  current occupancy

Function
REQ-006 Read accepted (rd_acc) SHALL be rd_en & !empty & !flush.
REQ-007 Write accepted (wr_acc) SHALL be wr_en & !flush & (!full | rd_acc); a write into a full FIFO with a simultaneous accepted read SHALL succeed, and count SHALL stay DEPTH.
REQ-008 When empty, rd_en with wr_en SHALL accept the write only; count SHALL become 1.
REQ-009 wr_ptr and rd_ptr SHALL advance by 1 on accept and wrap from DEPTH-1 to 0.
REQ-010 count SHALL update per cycle as +1 (write only), -1 (read only), or unchanged (both or neither).
REQ-011 FWFT_MODE=1: rd_data SHALL equal mem[rd_ptr] combinationally, rd_valid SHALL equal !empty, and rd_en consumes the displayed word.
REQ-012 FWFT_MODE=0: rd_data SHALL load mem[rd_ptr] on the edge after rd_acc; rd_valid SHALL pulse high for that one cycle; otherwise rd_data SHALL hold its value.
REQ-013 almost_full and almost_empty SHALL be combinational compares of the count register against the live thresholds.
REQ-014 overflow SHALL set on the edge after wr_en & !wr_acc & !flush; underflow SHALL set on the edge after rd_en & empty & !flush.
REQ-015 err_clr SHALL clear both sticky flags; a same-cycle set event SHALL win over err_clr.
REQ-016 flush SHALL override wr_en and rd_en: pointers, count and rd_valid SHALL go to 0 on the next edge; rd_data and the sticky flags SHALL be unchanged; memory contents are don't-care.

Reset
REQ-017 rst_n low SHALL asynchronously force wr_ptr, rd_ptr, count, rd_valid, overflow and underflow to 0 (empty=1, full=0, almost_empty=1 if ae_thresh>=0); memory SHALL NOT be reset.
REQ-018 FWFT_MODE=0: rd_data SHALL reset to 0; FWFT_MODE=1: rd_data SHALL be undefined until the first write.
REQ-019 Reset asserted mid-operation SHALL discard all contents; the first write after deassertion SHALL land in entry 0.

Configuration
REQ-020 With macro SYNC_FIFO_STATS_EN defined, output peak_count [CW] SHALL exist: a high-water mark of count, updated every cycle and cleared by rst_n, by flush, and by err_clr.
REQ-021 Without SYNC_FIFO_STATS_EN, there SHALL be no peak_count port and no associated logic.

Structure
REQ-022 Package sync_fifo_pkg SHALL hold the count-width function, a read-mode enum (SYNC_READ, FWFT_READ) and a pointer-increment-with-wrap function.
REQ-023 Storage SHALL be a sub-module sync_fifo_mem: one write port and one asynchronous read port, parameterised by WIDTH and DEPTH.

Verification (WIDTH=8, DEPTH=12, both FWFT_MODE values)
REQ-024 Write 0x01..0x0C -> full=1 after the 12th write; a 13th write sets overflow=1; reading back returns 0x01..0x0C in order with wrap-around.
REQ-025 Full FIFO, wr_en+rd_en for 20 cycles -> count stays 12, no overflow, data order preserved.
REQ-026 Empty FIFO, rd_en+wr_en(0xA5) -> underflow=1, count=1; FWFT: rd_data=0xA5 the same cycle the count reaches 1; sync: rd_data=0xA5 one cycle after the next read.
REQ-027 af_thresh=10, ae_thresh=2: fill to 9 -> almost_full=0; fill to 10 -> almost_full=1; almost_empty=1 only at count<=2.
REQ-028 count=7, flush with wr_en -> next cycle count=0, empty=1, overflow unchanged; err_clr with a coincident underflow -> underflow stays 1.
REQ-029 With SYNC_FIFO_STATS_EN: fill to 9, drain to 3 -> peak_count=9; flush -> peak_count=0. Asynchronous rst_n mid-burst -> all outputs are at reset values before the next edge.
